lfsr_plus: RTL and testbench



---
 rtl/lfsr_plus_pkg.sv | 48 ++++
 rtl/lfsr_leap.sv | 40 ++++
 rtl/lfsr_plus.sv | 86 ++++++++
 tb/tb_lfsr_plus.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_plus_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_plus_pkg
// Shared constants and helper functions for the lfsr_plus noise source:
//   LFSR_W      width of every Galois LFSR
//   LFSR_MASK   feedback mask for x^32+x^22+x^2+x+1 (right-shifting Galois form)
//   LFSR_SEED   per-generator reset seeds, all nonzero
//   galois_step one Galois shift
//   galois_leap n Galois shifts, unrolled combinationally for constant n
//   sat16       clamp a 32-bit signed value into the 16-bit signed range
// ----------------------------------------------------------------------------
package lfsr_plus_pkg;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int          MAX_LFSR  = 8;
  localparam int          MAX_LEAP  = 64;

  // Seeds 0..3 are the reference seeds; 4..7 only matter for wider sums.
  localparam logic [LFSR_W-1:0] LFSR_SEED [MAX_LFSR] = '{
    32'hACE1_2345, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D,
    32'h1F2E_3D4C, 32'h5A5A_1234, 32'hC0FF_EE11, 32'h7E57_AB1E
  };

  function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] state);
    return (state >> 1) ^ (state[0] ? LFSR_MASK : '0);
  endfunction

  // The loop has a fixed bound so it unrolls into a pure XOR network; the
  // guard on n selects how many of the unrolled steps are actually applied.
  function automatic logic [LFSR_W-1:0] galois_leap(input logic [LFSR_W-1:0] state,
                                                    input int              n);
    logic [LFSR_W-1:0] r;
    r = state;
    for (int i = 0; i < MAX_LEAP; i++) begin
      if (i < n) r = galois_step(r);
    end
    return r;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] value);
    logic signed [15:0] r;
    if (value > 32'sd32767)       r = 16'sh7FFF;
    else if (value < -32'sd32768) r = 16'sh8000;
    else                          r = value[15:0];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_leap.sv
// ----------------------------------------------------------------------------
// lfsr_leap
// One 32-bit Galois LFSR that advances STEPS shifts per enabled clock edge.
//   clk      rising-edge clock
//   n_reset  asynchronous active-low reset; loads SEED
//   enable   high: leap STEPS shifts this edge; low: hold
//   state    current (pre-advance) LFSR state
// ----------------------------------------------------------------------------
module lfsr_leap
  import lfsr_plus_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 32'hACE1_2345,
  parameter int                STEPS = 12
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // NOTE: combinational blocks use blocking '=' with a default first, so no
  // latch can be inferred; only the always_ff below uses non-blocking '<='.
  always_comb begin
    state_d = state_q;
    if (enable) state_d = galois_leap(state_q, STEPS);
  end

  // NOTE: every flop is reset to a known value; the seed must be nonzero or
  // the LFSR would sit in the all-zero state forever.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_plus.sv
// ----------------------------------------------------------------------------
// lfsr_plus
// Approximate Gaussian noise source: sums NUM_LFSR uniform SAMPLE_W-bit
// samples, each from its own leap-ahead Galois LFSR (central-limit approx).
//   clk                      rising-edge clock
//   n_reset                  asynchronous active-low reset (seeds, outputs 0)
//   enable                   high: register a new sample, advance all LFSRs
//   g_noise_out              raw unsigned sum, zero-extended to 16 bits
//   g_noise_out_scaled_mean  (sum - MEAN) <<< GAIN_SHIFT, saturated to 16 bits
// Outputs are registered and reflect the LFSR states held before the edge.
// ----------------------------------------------------------------------------
module lfsr_plus
  import lfsr_plus_pkg::*;
#(
  parameter int NUM_LFSR   = 4,
  parameter int SAMPLE_W   = 12,
  parameter int GAIN_SHIFT = 1
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               enable,
  output logic signed [15:0] g_noise_out,
  output logic signed [15:0] g_noise_out_scaled_mean
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_LFSR);
  // Midpoint of the sum range; exact because NUM_LFSR is even.
  localparam int MEAN  = NUM_LFSR * ((1 << SAMPLE_W) - 1) / 2;

  logic [LFSR_W-1:0]   lfsr_state [NUM_LFSR];
  logic [NUM_LFSR-1:0] unused_hi;

  for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
    lfsr_leap #(
      .SEED  (LFSR_SEED[i]),
      .STEPS (SAMPLE_W)
    ) u_lfsr (
      .clk     (clk),
      .n_reset (n_reset),
      .enable  (enable),
      .state   (lfsr_state[i])
    );
    // Only the low SAMPLE_W bits feed the sum; the rest only drive the LFSR.
    assign unused_hi[i] = ^lfsr_state[i][LFSR_W-1:SAMPLE_W];
  end

  logic [SUM_W-1:0]   sum;
  logic signed [31:0] diff;
  logic signed [31:0] shifted;

  logic signed [15:0] g_noise_q;
  logic signed [15:0] g_noise_d;
  logic signed [15:0] scaled_q;
  logic signed [15:0] scaled_d;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LFSR; i++) begin
      sum = sum + SUM_W'(lfsr_state[i][SAMPLE_W-1:0]);
    end
    // 32 bits comfortably covers SUM_W+1+GAIN_SHIFT for every legal setting.
    diff    = signed'(32'(sum)) - MEAN;
    shifted = diff <<< GAIN_SHIFT;

    g_noise_d = g_noise_q;
    scaled_d  = scaled_q;
    if (enable) begin
      g_noise_d = signed'(16'(sum));
      scaled_d  = sat16(shifted);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      g_noise_q <= '0;
      scaled_q  <= '0;
    end else begin
      g_noise_q <= g_noise_d;
      scaled_q  <= scaled_d;
    end
  end

  assign g_noise_out             = g_noise_q;
  assign g_noise_out_scaled_mean = scaled_q;

endmodule

// File: tb/tb_lfsr_plus.sv
// ----------------------------------------------------------------------------
// tb_lfsr_plus
// Self-checking bench for lfsr_plus. Two instances share stimulus: one with
// default parameters and one with GAIN_SHIFT=3 to reach saturation. An
// independent bit-serial model of the four LFSRs supplies expected samples.
// ----------------------------------------------------------------------------
module tb_lfsr_plus;

  localparam int          MEAN    = 8190;
  localparam logic [31:0] MASK    = 32'h8020_0003;
  localparam int          N_STATS = 65536;

  logic clk = 1'b0;
  logic n_reset;
  logic enable;

  logic signed [15:0] raw_a, scaled_a;
  logic signed [15:0] raw_b, scaled_b;

  always #5 clk = ~clk;

  lfsr_plus u_dut (
    .clk                     (clk),
    .n_reset                 (n_reset),
    .enable                  (enable),
    .g_noise_out             (raw_a),
    .g_noise_out_scaled_mean (scaled_a)
  );

  lfsr_plus #(.GAIN_SHIFT(3)) u_dut_g3 (
    .clk                     (clk),
    .n_reset                 (n_reset),
    .enable                  (enable),
    .g_noise_out             (raw_b),
    .g_noise_out_scaled_mean (scaled_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_state [4];
  int exp_sum, exp_scaled, exp_g3;

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_state[0] = 32'hACE1_2345;
    m_state[1] = 32'h1234_5678;
    m_state[2] = 32'hDEAD_BEEF;
    m_state[3] = 32'h0BAD_F00D;
    exp_sum = 0; exp_scaled = 0; exp_g3 = 0;
  endtask

  // Sample from the current state, then shift each register 12 times, one
  // bit at a time, feeding the output bit back through the tap mask.
  task automatic model_advance();
    logic [31:0] s;
    int total;
    total = 0;
    for (int i = 0; i < 4; i++) total += int'(m_state[i][11:0]);
    for (int i = 0; i < 4; i++) begin
      s = m_state[i];
      for (int k = 0; k < 12; k++) begin
        if (s[0]) s = {1'b0, s[31:1]} ^ MASK;
        else      s = {1'b0, s[31:1]};
      end
      m_state[i] = s;
    end
    exp_sum    = total;
    exp_scaled = (total - MEAN) * 2;
    exp_g3     = clamp16((total - MEAN) * 8);
  endtask

  // One clock: apply enable, advance the model when enabled, check 1 ns later.
  task automatic tick(input logic en);
    enable = en;
    if (en) model_advance();
    @(posedge clk);
    #1;
    check("raw",       int'(raw_a),    exp_sum);
    check("scaled",    int'(scaled_a), exp_scaled);
    check("raw_g3",    int'(raw_b),    exp_sum);
    check("scaled_g3", int'(scaled_b), exp_g3);
  endtask

  int rec_raw    [100];
  int rec_scaled [100];

  longint acc;
  int     n_sat_hi, n_sat_lo, n_centre, n_tails, n_range_bad;
  int     mean_scaled;

  initial begin
    n_reset = 1'b0;
    enable  = 1'b0;
    model_reset();

    // Reset held 200 ns, then idle 250 ns with enable low.
    #200;
    check("rst_raw",    int'(raw_a),    0);
    check("rst_scaled", int'(scaled_a), 0);
    n_reset = 1'b1;
    for (int i = 0; i < 25; i++) tick(1'b0);

    // First enabled edge, hand-computed: 837+1656+3823+13 = 6329.
    tick(1'b1);
    check("first_raw",       int'(raw_a),    6329);
    check("first_scaled",    int'(scaled_a), -3722);
    check("first_scaled_g3", int'(scaled_b), -14888);
    rec_raw[0]    = int'(raw_a);
    rec_scaled[0] = int'(scaled_a);

    // 999 more samples with a 10-cycle enable gap in the middle.
    for (int n = 1; n < 1000; n++) begin
      if (n == 400) for (int g = 0; g < 10; g++) tick(1'b0);
      tick(1'b1);
      if (n < 100) begin
        rec_raw[n]    = int'(raw_a);
        rec_scaled[n] = int'(scaled_a);
      end
    end

    // Asynchronous reset between edges: outputs clear without a clock.
    #2;
    n_reset = 1'b0;
    #1;
    check("async_rst_raw",    int'(raw_a),    0);
    check("async_rst_scaled", int'(scaled_a), 0);
    check("async_rst_g3",     int'(scaled_b), 0);
    model_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    for (int n = 0; n < 100; n++) begin
      tick(1'b1);
      check("replay_raw",    int'(raw_a),    rec_raw[n]);
      check("replay_scaled", int'(scaled_a), rec_scaled[n]);
    end

    // Long run: model tracks every cycle; gather range, mean, shape, saturation.
    acc = 0;
    n_sat_hi = 0; n_sat_lo = 0; n_centre = 0; n_tails = 0; n_range_bad = 0;
    for (int n = 0; n < N_STATS; n++) begin
      tick(1'b1);
      if (int'(raw_a) < 0 || int'(raw_a) > 16380) n_range_bad++;
      acc += longint'(scaled_a);
      if (scaled_a > -16'sd2048 && scaled_a < 16'sd2048) n_centre++;
      if (scaled_a > 16'sd12000 || scaled_a < -16'sd12000) n_tails++;
      if (exp_sum >= 12286) check("sat_hi_exact", int'(scaled_b), 32767);
      if (exp_sum <= 4093)  check("sat_lo_exact", int'(scaled_b), -32768);
      if (scaled_b == 16'sh7FFF) n_sat_hi++;
      if (scaled_b == 16'sh8000) n_sat_lo++;
    end
    mean_scaled = int'(acc / N_STATS);
    check("raw_out_of_range", n_range_bad, 0);
    check("mean_below_64", int'(mean_scaled > -64 && mean_scaled < 64), 1);
    check("centre_beats_tails", int'(n_centre > 2 * n_tails), 1);
    check("sat_hi_seen", int'(n_sat_hi > 0), 1);
    check("sat_lo_seen", int'(n_sat_lo > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
